// File: rtl/spi_reg_slave_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_reg_slave_if : SPI wire bundle (CS/SCLK/MOSI/MISO)  Rev 1.0    |
// +--------------------------------------------------------------------+
interface spi_reg_slave_if;
  logic spi_cs;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;

  modport slave (
    input  spi_cs,
    input  spi_sclk,
    input  spi_mosi,
    output spi_miso
  );

  modport master (
    output spi_cs,
    output spi_sclk,
    output spi_mosi,
    input  spi_miso
  );
endinterface
`default_nettype wire

// File: rtl/spi_reg_slave.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_reg_slave : mode-3 SPI register bank, oversampled in aclk      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module spi_reg_slave #(
  parameter int REG_COUNT   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  spi_reg_slave_if.slave         spi,
  output logic [REG_COUNT*8-1:0] reg_q,
  output logic                   wr_pulse,
  output logic [6:0]             wr_index,
  output logic                   rd_pulse,
  output logic                   frame_err
);

  localparam logic [7:0] C_REG_COUNT = 8'(REG_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_d_q;
  logic                   cs_d_q;

  logic cs_s;
  logic sclk_s;
  logic mosi_s;
  logic rise;
  logic cs_fall;

  state_t     state_q,     state_d;
  logic [2:0] bit_cnt_q,   bit_cnt_d;
  logic [6:0] addr_sr_q,   addr_sr_d;
  logic [6:0] data_sr_q,   data_sr_d;
  logic       rw_q,        rw_d;
  logic [6:0] idx_q,       idx_d;
  logic [7:0] tx_byte_q,   tx_byte_d;
  logic       miso_q,      miso_d;
  logic       wr_pulse_q,  wr_pulse_d;
  logic       rd_pulse_q,  rd_pulse_d;
  logic       frame_err_q, frame_err_d;
  logic [6:0] wr_index_q,  wr_index_d;

  logic [6:0] addr_idx;
  logic [7:0] rd_byte;
  logic [7:0] wr_byte;
  logic       idx_mapped;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '1;
      mosi_sync_q <= '1;
      sclk_d_q    <= 1'b1;
      cs_d_q      <= 1'b1;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   spi.spi_cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.spi_mosi};
      sclk_d_q    <= sclk_s;
      cs_d_q      <= cs_s;
    end
  end

  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_d_q & ~cs_s;
  assign cs_fall = ~cs_s & cs_d_q;

  // Address and data bytes are completed with the live MOSI bit on the 8th rise.
  assign addr_idx   = {addr_sr_q[5:0], mosi_s};
  assign wr_byte    = {data_sr_q, mosi_s};
  assign idx_mapped = ({1'b0, idx_q} < C_REG_COUNT);

  always_comb begin
    rd_byte = 8'h00;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (addr_idx == 7'(i)) begin
        rd_byte = reg_q[i*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    addr_sr_d   = addr_sr_q;
    data_sr_d   = data_sr_q;
    rw_d        = rw_q;
    idx_d       = idx_q;
    tx_byte_d   = tx_byte_q;
    wr_pulse_d  = 1'b0;
    rd_pulse_d  = 1'b0;
    frame_err_d = 1'b0;
    wr_index_d  = wr_index_q;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_ADDR;
          bit_cnt_d = 3'd0;
        end
      end
      ST_ADDR: begin
        if (cs_s) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (rise) begin
          addr_sr_d = {addr_sr_q[5:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rw_d      = addr_sr_q[6];
            idx_d     = addr_idx;
            bit_cnt_d = 3'd0;
            state_d   = ST_DATA;
            if (addr_sr_q[6]) begin
              tx_byte_d  = rd_byte;
              rd_pulse_d = 1'b1;
            end
          end
        end
      end
      ST_DATA: begin
        // A CS release in the same cycle as the final rise still aborts.
        if (cs_s) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (rise) begin
          data_sr_d = {data_sr_q[5:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            state_d   = ST_DONE;
            if (!rw_q && idx_mapped) begin
              wr_pulse_d = 1'b1;
              wr_index_d = idx_q;
            end
          end
        end
      end
      ST_DONE: begin
        if (cs_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    miso_d = 1'b1;
    if ((state_d == ST_DATA) && rw_d) begin
      miso_d = tx_byte_d[3'd7 - bit_cnt_d];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      addr_sr_q   <= 7'd0;
      data_sr_q   <= 7'd0;
      rw_q        <= 1'b0;
      idx_q       <= 7'd0;
      tx_byte_q   <= 8'h00;
      miso_q      <= 1'b1;
      wr_pulse_q  <= 1'b0;
      rd_pulse_q  <= 1'b0;
      frame_err_q <= 1'b0;
      wr_index_q  <= 7'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_sr_q   <= addr_sr_d;
      data_sr_q   <= data_sr_d;
      rw_q        <= rw_d;
      idx_q       <= idx_d;
      tx_byte_q   <= tx_byte_d;
      miso_q      <= miso_d;
      wr_pulse_q  <= wr_pulse_d;
      rd_pulse_q  <= rd_pulse_d;
      frame_err_q <= frame_err_d;
      wr_index_q  <= wr_index_d;
    end
  end

  for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_regs
    logic [7:0] byte_q;

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        byte_q <= 8'h00;
      end else if (wr_pulse_d && (idx_q == 7'(gi))) begin
        byte_q <= wr_byte;
      end
    end

    assign reg_q[gi*8 +: 8] = byte_q;
  end

  assign spi.spi_miso = miso_q;
  assign wr_pulse     = wr_pulse_q;
  assign wr_index     = wr_index_q;
  assign rd_pulse     = rd_pulse_q;
  assign frame_err    = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_spi_reg_slave : directed mode-3 SPI master bench  Rev 1.0       |
// +--------------------------------------------------------------------+
module tb_spi_reg_slave;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [127:0] reg_q;
  logic         wr_pulse;
  logic [6:0]   wr_index;
  logic         rd_pulse;
  logic         frame_err;

  spi_reg_slave_if spi_bus ();

  spi_reg_slave #(
    .REG_COUNT   (16),
    .SYNC_STAGES (2)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .spi       (spi_bus),
    .reg_q     (reg_q),
    .wr_pulse  (wr_pulse),
    .wr_index  (wr_index),
    .rd_pulse  (rd_pulse),
    .frame_err (frame_err)
  );

  always #5 aclk = ~aclk;

  int           total = 0;
  int           bad   = 0;
  int           wr_cnt = 0;
  int           rd_cnt = 0;
  int           fe_cnt = 0;
  logic [6:0]   wr_idx_seen = 7'd0;
  logic [127:0] exp_img;

  always @(negedge aclk) begin
    if (wr_pulse) begin
      wr_cnt++;
      wr_idx_seen = wr_index;
    end
    if (rd_pulse)  rd_cnt++;
    if (frame_err) fe_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // SCLK half period of 8 aclk; MOSI changes on the fall, MISO sampled mid-low.
  task automatic clk_bit(input logic b, output logic m);
    spi_bus.spi_sclk = 1'b0;
    spi_bus.spi_mosi = b;
    cyc(4);
    m = spi_bus.spi_miso;
    cyc(4);
    spi_bus.spi_sclk = 1'b1;
    cyc(8);
  endtask

  task automatic frame(input logic [31:0] bits, input int nbits, output logic [7:0] rx);
    logic m;
    rx = 8'h00;
    spi_bus.spi_cs = 1'b0;
    cyc(4);
    for (int i = 0; i < nbits; i++) begin
      clk_bit(bits[nbits-1-i], m);
      if (i >= 8 && i < 16) rx = {rx[6:0], m};
    end
    cyc(4);
    spi_bus.spi_cs = 1'b1;
    cyc(8);
  endtask

  task automatic test_reset;
    aresetn          = 1'b0;
    spi_bus.spi_cs   = 1'b1;
    spi_bus.spi_sclk = 1'b1;
    spi_bus.spi_mosi = 1'b1;
    cyc(3);
    total++; if (spi_bus.spi_miso !== 1'b1) begin bad++; $display("FAIL reset_miso: got %b want 1", spi_bus.spi_miso); end
    total++; if (reg_q !== 128'h0) begin bad++; $display("FAIL reset_regs: got %h want 0", reg_q); end
    total++; if (wr_pulse !== 1'b0) begin bad++; $display("FAIL reset_wr_pulse: got %b want 0", wr_pulse); end
    total++; if (rd_pulse !== 1'b0) begin bad++; $display("FAIL reset_rd_pulse: got %b want 0", rd_pulse); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    total++; if (wr_index !== 7'd0) begin bad++; $display("FAIL reset_wr_index: got %0d want 0", wr_index); end
    aresetn = 1'b1;
    cyc(4);
    exp_img = '0;
  endtask

  task automatic test_write;
    logic [7:0] rx;
    int wb;
    wb = wr_cnt;
    frame(32'h05A5, 16, rx);
    exp_img[47:40] = 8'hA5;
    total++; if (reg_q !== exp_img) begin bad++; $display("FAIL write_img: got %h want %h", reg_q, exp_img); end
    total++; if (wr_cnt - wb !== 1) begin bad++; $display("FAIL write_pulses: got %0d want 1", wr_cnt - wb); end
    total++; if (wr_idx_seen !== 7'd5) begin bad++; $display("FAIL write_index: got %0d want 5", wr_idx_seen); end
    total++; if (spi_bus.spi_miso !== 1'b1) begin bad++; $display("FAIL write_miso_idle: got %b want 1", spi_bus.spi_miso); end
  endtask

  task automatic test_read;
    logic [7:0] rx;
    int wb, rb;
    wb = wr_cnt;
    rb = rd_cnt;
    frame(32'h8500, 16, rx);
    total++; if (rx !== 8'hA5) begin bad++; $display("FAIL read_data: got %h want a5", rx); end
    total++; if (rd_cnt - rb !== 1) begin bad++; $display("FAIL read_pulses: got %0d want 1", rd_cnt - rb); end
    total++; if (wr_cnt - wb !== 0) begin bad++; $display("FAIL read_no_write: got %0d want 0", wr_cnt - wb); end
    total++; if (reg_q !== exp_img) begin bad++; $display("FAIL read_img: got %h want %h", reg_q, exp_img); end
  endtask

  task automatic test_unmapped;
    logic [7:0] rx;
    int wb, rb;
    wb = wr_cnt;
    frame(32'h7F3C, 16, rx);
    frame(32'h103C, 16, rx);
    total++; if (wr_cnt - wb !== 0) begin bad++; $display("FAIL unmapped_pulses: got %0d want 0", wr_cnt - wb); end
    total++; if (reg_q !== exp_img) begin bad++; $display("FAIL unmapped_img: got %h want %h", reg_q, exp_img); end
    rb = rd_cnt;
    frame(32'hFF00, 16, rx);
    total++; if (rx !== 8'h00) begin bad++; $display("FAIL unmapped_read: got %h want 00", rx); end
    total++; if (rd_cnt - rb !== 1) begin bad++; $display("FAIL unmapped_rd_pulse: got %0d want 1", rd_cnt - rb); end
    frame(32'h0F5A, 16, rx);
    exp_img[127:120] = 8'h5A;
    total++; if (wr_idx_seen !== 7'd15) begin bad++; $display("FAIL top_index: got %0d want 15", wr_idx_seen); end
    frame(32'h8F00, 16, rx);
    total++; if (rx !== 8'h5A) begin bad++; $display("FAIL top_read: got %h want 5a", rx); end
    total++; if (reg_q !== exp_img) begin bad++; $display("FAIL top_img: got %h want %h", reg_q, exp_img); end
  endtask

  task automatic test_abort;
    logic [7:0] rx;
    int wb, fb;
    wb = wr_cnt;
    fb = fe_cnt;
    frame(32'h02A, 12, rx);
    total++; if (fe_cnt - fb !== 1) begin bad++; $display("FAIL abort_frame_err: got %0d want 1", fe_cnt - fb); end
    total++; if (wr_cnt - wb !== 0) begin bad++; $display("FAIL abort_no_write: got %0d want 0", wr_cnt - wb); end
    total++; if (reg_q !== exp_img) begin bad++; $display("FAIL abort_img: got %h want %h", reg_q, exp_img); end
    frame(32'h0277, 16, rx);
    exp_img[23:16] = 8'h77;
    total++; if (reg_q !== exp_img) begin bad++; $display("FAIL abort_next_img: got %h want %h", reg_q, exp_img); end
    total++; if (wr_idx_seen !== 7'd2) begin bad++; $display("FAIL abort_next_index: got %0d want 2", wr_idx_seen); end
    total++; if (fe_cnt - fb !== 1) begin bad++; $display("FAIL abort_next_clean: got %0d want 1", fe_cnt - fb); end
  endtask

  task automatic test_long_frame;
    logic [7:0] rx;
    int wb, fb;
    wb = wr_cnt;
    fb = fe_cnt;
    frame(32'h0111FF, 24, rx);
    exp_img[15:8] = 8'h11;
    total++; if (reg_q !== exp_img) begin bad++; $display("FAIL long_img: got %h want %h", reg_q, exp_img); end
    total++; if (wr_cnt - wb !== 1) begin bad++; $display("FAIL long_pulses: got %0d want 1", wr_cnt - wb); end
    total++; if (fe_cnt - fb !== 0) begin bad++; $display("FAIL long_frame_err: got %0d want 0", fe_cnt - fb); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] rx;
    frame(32'h03C3, 16, rx);
    exp_img[31:24] = 8'hC3;
    frame(32'h8300, 16, rx);
    total++; if (rx !== 8'hC3) begin bad++; $display("FAIL b2b_read: got %h want c3", rx); end
    frame(32'h8200, 16, rx);
    total++; if (rx !== 8'h77) begin bad++; $display("FAIL b2b_read_reg2: got %h want 77", rx); end
    total++; if (reg_q !== exp_img) begin bad++; $display("FAIL b2b_img: got %h want %h", reg_q, exp_img); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] v;
    logic [7:0]  rx;
    logic        m;
    v = 16'h06EE;
    spi_bus.spi_cs = 1'b0;
    cyc(4);
    for (int i = 0; i < 10; i++) clk_bit(v[15-i], m);
    #2;
    aresetn = 1'b0;
    #1;
    total++; if (spi_bus.spi_miso !== 1'b1) begin bad++; $display("FAIL midreset_miso: got %b want 1", spi_bus.spi_miso); end
    total++; if (reg_q !== 128'h0) begin bad++; $display("FAIL midreset_regs: got %h want 0", reg_q); end
    spi_bus.spi_cs   = 1'b1;
    spi_bus.spi_sclk = 1'b1;
    cyc(3);
    aresetn = 1'b1;
    cyc(4);
    exp_img = '0;
    frame(32'h0499, 16, rx);
    exp_img[39:32] = 8'h99;
    total++; if (reg_q !== exp_img) begin bad++; $display("FAIL midreset_next_img: got %h want %h", reg_q, exp_img); end
    total++; if (wr_idx_seen !== 7'd4) begin bad++; $display("FAIL midreset_next_index: got %0d want 4", wr_idx_seen); end
    frame(32'h8400, 16, rx);
    total++; if (rx !== 8'h99) begin bad++; $display("FAIL midreset_readback: got %h want 99", rx); end
    frame(32'h8600, 16, rx);
    total++; if (rx !== 8'h00) begin bad++; $display("FAIL midreset_reg6: got %h want 00", rx); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_unmapped;
    test_abort;
    test_long_frame;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
